// File: rtl/bcd_chain_counter_if.sv
// Control and count bus of the cascadable BCD counter.
// The counter drives the slave side; whoever controls the counter uses the master side.
interface bcd_chain_counter_if #(parameter int DIGITS = 2);
    logic                  Enable;
    logic                  Up;
    logic                  Load;
    logic [4*DIGITS-1:0]   LoadValue;
    logic [4*DIGITS-1:0]   Count;
    logic                  Carry;
    logic                  Borrow;
    logic                  Terminal;
    logic                  LoadError;

    modport master (
        output Enable, Up, Load, LoadValue,
        input  Count, Carry, Borrow, Terminal, LoadError
    );
    modport slave (
        input  Enable, Up, Load, LoadValue,
        output Count, Carry, Borrow, Terminal, LoadError
    );
endinterface

// File: rtl/bcd_chain_counter.sv
// Multi-decade synchronous BCD up/down counter with load, wrap/saturate mode
// and cascade outputs (Terminal, Carry/Borrow pulses, LoadError).
module bcd_chain_digit (
    input  logic [3:0] d,
    input  logic       up,
    input  logic       step,
    output logic [3:0] nxt
);
    always_comb begin
        nxt = d;
        if (step) begin
            if (up) nxt = (d >= 4'd9) ? 4'd0 : d + 4'd1;
            else    nxt = (d == 4'd0) ? 4'd9 : d - 4'd1;
        end
    end
endmodule

module bcd_chain_counter #(
    parameter int DIGITS   = 2,
    parameter bit SATURATE = 1'b0
) (
    input  logic CLK,
    input  logic Clear,
    bcd_chain_counter_if.slave bus
);
    logic [DIGITS-1:0][3:0] cnt;
    logic [DIGITS-1:0][3:0] cnt_step;
    logic [DIGITS-1:0][3:0] ld_val;
    logic [DIGITS-1:0]      ld_bad;
    logic [DIGITS:0]        pre9;
    logic [DIGITS:0]        pre0;
    logic                   all9;
    logic                   all0;
    logic                   at_bound;
    logic                   carry;
    logic                   borrow;

    assign pre9[0] = 1'b1;
    assign pre0[0] = 1'b1;

    // pre9[i]/pre0[i]: every digit below i is at 9/0, i.e. digit i steps this edge
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        assign pre9[i+1]  = pre9[i] & (cnt[i] == 4'd9);
        assign pre0[i+1]  = pre0[i] & (cnt[i] == 4'd0);
        assign ld_bad[i]  = bus.LoadValue[4*i +: 4] > 4'd9;
        assign ld_val[i]  = ld_bad[i] ? 4'd0 : bus.LoadValue[4*i +: 4];

        bcd_chain_digit u_dig (
            .d    (cnt[i]),
            .up   (bus.Up),
            .step (bus.Up ? pre9[i] : pre0[i]),
            .nxt  (cnt_step[i])
        );
    end

    assign all9     = pre9[DIGITS];
    assign all0     = pre0[DIGITS];
    assign at_bound = bus.Up ? all9 : all0;
    assign carry    = bus.Up & all9;
    assign borrow   = ~bus.Up & all0;

    always_ff @(posedge CLK) begin
        if (Clear) begin
            cnt           <= '0;
            bus.Carry     <= 1'b0;
            bus.Borrow    <= 1'b0;
            bus.LoadError <= 1'b0;
        end else if (bus.Load) begin
            cnt           <= ld_val;
            bus.Carry     <= 1'b0;
            bus.Borrow    <= 1'b0;
            bus.LoadError <= |ld_bad;
        end else if (bus.Enable) begin
            // In saturate mode the bound is sticky and no wrap pulse is produced
            if (!(SATURATE && at_bound)) cnt <= cnt_step;
            bus.Carry     <= carry & ~SATURATE;
            bus.Borrow    <= borrow & ~SATURATE;
            bus.LoadError <= 1'b0;
        end else begin
            bus.Carry     <= 1'b0;
            bus.Borrow    <= 1'b0;
            bus.LoadError <= 1'b0;
        end
    end

    assign bus.Count    = cnt;
    assign bus.Terminal = at_bound;
endmodule

// File: doc/bcd_chain_counter.md
# bcd_chain_counter

Parametrised multi-digit synchronous BCD counter: the next generation of the team's single-digit decade counter. It generalises to DIGITS cascaded decades and adds up/down counting, count enable, synchronous parallel load, a wrap-or-saturate mode, and cascade outputs (terminal count, carry/borrow pulses). It sits in the display and timer datapaths, driving 7-segment decoders. It can be chained with further instances through Terminal/Enable.

## Interface
- DIGITS, 2, number of BCD decades (1..8); count width is 4*DIGITS
- SATURATE, 0, 0 = wrap at bounds, 1 = hold at bounds
- CLK  input  1  clock; all state updates on rising edge
- Clear  input  1  synchronous active-high reset
- Enable  input  1  count enable, sampled on the rising edge
- Up  input  1  direction: 1 = increment, 0 = decrement
- Load  input  1  synchronous parallel load strobe
- LoadValue  input  4*DIGITS  BCD value to load; digit i occupies bits [4i+3:4i], digit 0 is least significant
- Count  output  4*DIGITS  registered BCD count
- Carry  output  1  registered one-cycle pulse on up-wrap
- Borrow  output  1  registered one-cycle pulse on down-wrap
- Terminal  output  1  combinational; high when Count is at the bound for the current direction
- LoadError  output  1  registered one-cycle pulse when a loaded digit was > 9

## Operation
- Priority per edge: Clear > Load > Enable. With none active, the counter holds.
- Clear: Count = 0, Carry = 0, Borrow = 0, LoadError = 0.
- Load:
  - Count takes LoadValue digit by digit.
  - Any digit > 9 (values 10..15) is loaded as 0, and LoadError pulses.
  - Carry and Borrow are 0 on a load cycle.
- Enable with Up = 1:
  - Digit 0 increments. Digit i increments only when digits 0..i-1 are all 9.
  - A digit at 9 that increments becomes 0.
  - At all-9s: if SATURATE = 0, Count becomes all-0 and Carry pulses. If SATURATE = 1, Count holds and Carry stays 0.
- Enable with Up = 0:
  - Digit 0 decrements. Digit i decrements only when digits 0..i-1 are all 0.
  - A digit at 0 that decrements becomes 9.
  - At all-0: if SATURATE = 0, Count becomes all-9s and Borrow pulses. If SATURATE = 1, Count holds and Borrow stays 0.
- Terminal = (Up & Count == all-9s) | (~Up & Count == all-0). It does not depend on Enable.
  - Cascading: feed the next stage Enable with (this Enable & Terminal).
- Count never holds a non-BCD digit (no digit outside 0..9) after any edge.
- Direction may change on any cycle. The new Up value applies on that edge with no extra latency.

## Timing
- Reset values: Count = 0, Carry = 0, Borrow = 0, LoadError = 0. Terminal is then 1 if Up = 0 and 0 if Up = 1.
- Count/load latency: Count shows the new value one edge after Enable/Load is sampled high.
- Carry, Borrow and LoadError assert in the same cycle that Count shows the wrapped or loaded value. They are high for exactly one cycle unless the triggering event repeats.
  - Example: DIGITS = 1, SATURATE = 0, Up = 1, Enable held high gives a Carry pulse every 10 cycles.
- Terminal follows Count and Up combinationally within the same cycle.
- Clear mid-count or simultaneous with Load/Enable wins. The count is 0 on the next edge and any pending pulse is suppressed.
- Load together with Enable: the load wins and no increment is applied that cycle.
- Enable low: Count holds and all pulse outputs are 0.

## Test plan
- Reset/hold (DIGITS = 2): assert Clear 1 cycle, then Enable = 0 for 5 cycles -> Count = 0x00, Carry = Borrow = LoadError = 0 throughout.
- Up-wrap (DIGITS = 2, SATURATE = 0): Load 0x98, Up = 1, Enable 2 cycles -> Count 0x99 (Terminal = 1), then 0x00 with Carry = 1 for one cycle only.
- Down-wrap with decade borrow: Load 0x10, Up = 0, Enable 1 cycle -> 0x09. Load 0x00, Enable 1 cycle -> 0x99 with Borrow = 1.
- Saturate (SATURATE = 1): Load 0x99, Up = 1, Enable 3 cycles -> Count stays 0x99, Carry stays 0. Then Up = 0, Enable 1 cycle -> 0x98.
- Invalid load: LoadValue 0xA7 with Load -> Count = 0x07 and LoadError = 1 for one cycle. LoadValue 0x3F -> Count = 0x30 and LoadError = 1.
- Priority: Clear, Load (0x55) and Enable all high together -> Count = 0x00. Load and Enable high from 0x12 -> Count = 0x55. Direction flip: from 0x50, Up = 1 then Up = 0 on consecutive enabled edges -> 0x51, then 0x50.
